// File: rtl/get_root_cardinality.sv
// get_root_cardinality: scans every PU once per go and builds per-root defect
// parity and, with ROOT_BOUNDARY_TRACK_EN, per-root boundary contact.
// Ports: clk, reset (sync, high), go, is_defects, roots,
//   is_touching_boundaries (macro only), is_odd_cardinalities,
//   root_touching_boundaries (macro only), busy, done.
module get_root_cardinality #(
  parameter int CODE_DISTANCE_X = 4,
  parameter int CODE_DISTANCE_Z = 12,
  localparam int MEASUREMENT_ROUNDS =
    (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
  localparam int PER_DIMENSION_WIDTH = $clog2(MEASUREMENT_ROUNDS),
  localparam int ADDRESS_WIDTH = 3 * PER_DIMENSION_WIDTH,
  localparam int PU_COUNT =
    CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              go,
  input  logic [PU_COUNT-1:0]               is_defects,
  input  logic [ADDRESS_WIDTH*PU_COUNT-1:0] roots,
`ifdef ROOT_BOUNDARY_TRACK_EN
  input  logic [PU_COUNT-1:0]               is_touching_boundaries,
  output logic [PU_COUNT-1:0]               root_touching_boundaries,
`endif
  output logic [PU_COUNT-1:0]               is_odd_cardinalities,
  output logic                              busy,
  output logic                              done
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int IW = $clog2(PU_COUNT);
  localparam logic [AW-1:0] LAST = AW'(PU_COUNT - 1);
  localparam logic [AW-1:0] LIMIT = AW'(PU_COUNT);

  typedef enum logic [2:0] {
    IDLE, CLEAR, SCAN, DRAIN, FINISH
  } state_t;

  state_t state_q, state_d;
  logic [AW-1:0] index_q, index_d;
  logic s1_valid_q, s1_valid_d;
  logic s1_defect_q, s1_defect_d;
  logic [AW-1:0] s1_root_q, s1_root_d;
  logic [PU_COUNT-1:0] odd_q, odd_d;

  logic [PU_COUNT-1:0][AW-1:0] roots_2d;
  logic [IW-1:0] idx;
  logic [IW-1:0] ridx;
  logic root_ok;

  assign roots_2d = roots;
  assign idx = index_q[IW-1:0];
  assign ridx = s1_root_q[IW-1:0];
  // out-of-range roots are dropped rather than aliased onto a low bit
  assign root_ok = s1_root_q < LIMIT;

`ifdef ROOT_BOUNDARY_TRACK_EN
  logic s1_bnd_q, s1_bnd_d;
  logic [PU_COUNT-1:0] bnd_q, bnd_d;
`endif

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    s1_valid_d = 1'b0;
    s1_defect_d = is_defects[idx];
    s1_root_d = roots_2d[idx];
    odd_d = odd_q;
    if (s1_valid_q && s1_defect_q && root_ok)
      odd_d[ridx] = ~odd_q[ridx];
`ifdef ROOT_BOUNDARY_TRACK_EN
    s1_bnd_d = is_touching_boundaries[idx];
    bnd_d = bnd_q;
    if (s1_valid_q && s1_bnd_q && root_ok)
      bnd_d[ridx] = 1'b1;
`endif
    unique case (state_q)
      IDLE: begin
        if (go) state_d = CLEAR;
      end
      CLEAR: begin
        odd_d = '0;
`ifdef ROOT_BOUNDARY_TRACK_EN
        bnd_d = '0;
`endif
        index_d = '0;
        state_d = SCAN;
      end
      SCAN: begin
        s1_valid_d = 1'b1;
        index_d = index_q + 1'b1;
        if (index_q == LAST) state_d = DRAIN;
      end
      DRAIN: state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      index_q <= '0;
      s1_valid_q <= 1'b0;
      s1_defect_q <= 1'b0;
      s1_root_q <= '0;
      odd_q <= '0;
`ifdef ROOT_BOUNDARY_TRACK_EN
      s1_bnd_q <= 1'b0;
      bnd_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      s1_valid_q <= s1_valid_d;
      s1_defect_q <= s1_defect_d;
      s1_root_q <= s1_root_d;
      odd_q <= odd_d;
`ifdef ROOT_BOUNDARY_TRACK_EN
      s1_bnd_q <= s1_bnd_d;
      bnd_q <= bnd_d;
`endif
    end
  end

  assign is_odd_cardinalities = odd_q;
`ifdef ROOT_BOUNDARY_TRACK_EN
  assign root_touching_boundaries = bnd_q;
`endif
  assign busy = (state_q != IDLE);
  assign done = (state_q == FINISH);

endmodule

// File: tb/tb_get_root_cardinality.sv
// tb_get_root_cardinality: scoreboard bench for get_root_cardinality.
// Expected vectors are queued at go and popped at done.
module tb_get_root_cardinality;
  localparam int N = 576;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic go = 1'b0;
  logic [N-1:0] is_defects = '0;
  logic [N-1:0][AW-1:0] roots_tb = '0;
  logic [N-1:0] is_odd;
  logic busy;
  logic done;
  logic [N-1:0] is_tb = '0;
  logic [N-1:0] rtb;

  int vectors = 0;
  int miscompares = 0;
  int done_cyc;
  int done_cnt;
  logic busy1;
  logic [N-1:0] snap_odd;
  logic [N-1:0] snap_bnd;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] bexp_q[$];

  always #5 clk = ~clk;

  get_root_cardinality dut (
    .clk(clk),
    .reset(reset),
    .go(go),
    .is_defects(is_defects),
    .roots(roots_tb),
`ifdef ROOT_BOUNDARY_TRACK_EN
    .is_touching_boundaries(is_tb),
    .root_touching_boundaries(rtb),
`endif
    .is_odd_cardinalities(is_odd),
    .busy(busy),
    .done(done)
  );

`ifndef ROOT_BOUNDARY_TRACK_EN
  assign rtb = '0;
`endif

  function automatic logic [N-1:0] model_odd();
    logic [N-1:0] m;
    int r;
    m = '0;
    for (int p = 0; p < N; p++) begin
      r = int'(roots_tb[p]);
      if (is_defects[p] && r < N) m[r] = ~m[r];
    end
    return m;
  endfunction

  function automatic logic [N-1:0] model_bnd();
    logic [N-1:0] m;
    int r;
    m = '0;
    for (int p = 0; p < N; p++) begin
      r = int'(roots_tb[p]);
      if (is_tb[p] && r < N) m[r] = 1'b1;
    end
    return m;
  endfunction

  task automatic clear_inputs();
    is_defects = '0;
    roots_tb = '0;
    is_tb = '0;
  endtask

  task automatic push_expected();
    exp_q.push_back(model_odd());
    bexp_q.push_back(model_bnd());
  endtask

  // go in cycle 0; watches through cycle 700, optionally re-pulsing go
  task automatic run_scan(input int go_again_at);
    int cyc;
    @(posedge clk); #1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    busy1 = busy;
    cyc = 1;
    done_cyc = -1;
    done_cnt = 0;
    while (cyc < 700) begin
      @(posedge clk); #1;
      cyc++;
      go = (cyc == go_again_at);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          snap_odd = is_odd;
          snap_bnd = rtb;
        end
      end
    end
    go = 1'b0;
  endtask

  task automatic check_run(input string name);
    logic [N-1:0] e;
    logic [N-1:0] b;
    e = exp_q.pop_front();
    b = bexp_q.pop_front();
    vectors++;
    if (done_cyc !== 579) begin
      miscompares++;
      $display("FAIL %s done_cycle: got %0d want 579", name, done_cyc);
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++;
      $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
    end
    vectors++;
    if (snap_odd !== e) begin
      miscompares++;
      $display("FAIL %s odd: got %h want %h", name, snap_odd, e);
    end
`ifdef ROOT_BOUNDARY_TRACK_EN
    vectors++;
    if (snap_bnd !== b) begin
      miscompares++;
      $display("FAIL %s bnd: got %h want %h", name, snap_bnd, b);
    end
`endif
  endtask

  task automatic test_reset();
    int saw_done;
    int saw_busy;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    saw_done = 0;
    saw_busy = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) saw_done++;
      if (busy) saw_busy++;
    end
    vectors++;
    if (saw_done !== 0) begin
      miscompares++;
      $display("FAIL reset_done: got %0d want 0", saw_done);
    end
    vectors++;
    if (saw_busy !== 0) begin
      miscompares++;
      $display("FAIL reset_busy: got %0d want 0", saw_busy);
    end
    vectors++;
    if (is_odd !== '0) begin
      miscompares++;
      $display("FAIL reset_odd: got %h want 0", is_odd);
    end
    vectors++;
    if (rtb !== '0) begin
      miscompares++;
      $display("FAIL reset_bnd: got %h want 0", rtb);
    end
  endtask

  task automatic test_pair_cancel();
    clear_inputs();
    is_defects[5] = 1'b1;
    roots_tb[5] = 12'd5;
    is_defects[9] = 1'b1;
    roots_tb[9] = 12'd5;
    push_expected();
    run_scan(-1);
    check_run("pair");
    vectors++;
    if (busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL pair_busy_c1: got %b want 1", busy1);
    end
    vectors++;
    if (snap_odd !== '0) begin
      miscompares++;
      $display("FAIL pair_zero: got %h want 0", snap_odd);
    end
  endtask

  task automatic test_triple();
    clear_inputs();
    is_defects[3] = 1'b1;
    is_defects[7] = 1'b1;
    is_defects[20] = 1'b1;
    roots_tb[3] = 12'd3;
    roots_tb[7] = 12'd3;
    roots_tb[20] = 12'd3;
    push_expected();
    run_scan(-1);
    check_run("triple");
    vectors++;
    if (snap_odd[3] !== 1'b1 || $countones(snap_odd) != 1) begin
      miscompares++;
      $display("FAIL triple_bit3: got %h want only bit 3", snap_odd);
    end
    is_defects[3] = 1'b0;
    push_expected();
    run_scan(-1);
    check_run("rerun");
    vectors++;
    if (snap_odd !== '0) begin
      miscompares++;
      $display("FAIL rerun_clear: got %h want 0", snap_odd);
    end
  endtask

  task automatic test_last_index();
    clear_inputs();
    is_defects[575] = 1'b1;
    roots_tb[575] = 12'd575;
    push_expected();
    run_scan(100);
    check_run("last");
    vectors++;
    if (snap_odd[575] !== 1'b1) begin
      miscompares++;
      $display("FAIL last_bit575: got %b want 1", snap_odd[575]);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignored_go_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    int saw_done;
    clear_inputs();
    is_defects[3] = 1'b1;
    is_defects[7] = 1'b1;
    is_defects[20] = 1'b1;
    roots_tb[3] = 12'd3;
    roots_tb[7] = 12'd3;
    roots_tb[20] = 12'd3;
    @(posedge clk); #1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    cyc = 1;
    saw_done = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (done) saw_done++;
    end
    vectors++;
    if (is_odd[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_midscan: got %b want 1", is_odd[3]);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_busy: got %b want 0", busy);
    end
    vectors++;
    if (is_odd !== '0) begin
      miscompares++;
      $display("FAIL abort_odd: got %h want 0", is_odd);
    end
    repeat (400) begin
      @(posedge clk); #1;
      if (done) saw_done++;
    end
    vectors++;
    if (saw_done !== 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d want 0", saw_done);
    end
    push_expected();
    run_scan(-1);
    check_run("after_abort");
  endtask

  task automatic test_out_of_range();
    logic [N-1:0] e;
    clear_inputs();
    is_defects[2] = 1'b1;
    roots_tb[2] = 12'd2;
    is_defects[10] = 1'b1;
    roots_tb[10] = 12'd4095;
    is_defects[11] = 1'b1;
    roots_tb[11] = 12'd576;
    push_expected();
    run_scan(-1);
    check_run("oor");
    e = '0;
    e[2] = 1'b1;
    vectors++;
    if (snap_odd !== e) begin
      miscompares++;
      $display("FAIL oor_only_bit2: got %h want %h", snap_odd, e);
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    is_defects[30] = 1'b1;
    is_defects[31] = 1'b1;
    is_defects[32] = 1'b1;
    is_defects[33] = 1'b1;
    is_defects[34] = 1'b1;
    roots_tb[30] = 12'd8;
    roots_tb[31] = 12'd8;
    roots_tb[32] = 12'd8;
    roots_tb[33] = 12'd9;
    roots_tb[34] = 12'd9;
    push_expected();
    run_scan(-1);
    check_run("b2b");
    vectors++;
    if (snap_odd[8] !== 1'b1 || snap_odd[9] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_bits: got %b%b want 01", snap_odd[9], snap_odd[8]);
    end
  endtask

  task automatic test_random();
    clear_inputs();
    for (int k = 0; k < 60; k++) begin
      is_defects[$urandom_range(N - 1)] = 1'b1;
    end
    for (int p = 0; p < N; p++) begin
      roots_tb[p] = AW'($urandom_range(N - 1) % 40);
      is_tb[p] = ($urandom_range(15) == 0);
    end
    push_expected();
    run_scan(-1);
    check_run("random");
  endtask

`ifdef ROOT_BOUNDARY_TRACK_EN
  task automatic test_boundary();
    logic [N-1:0] e;
    clear_inputs();
    is_tb[40] = 1'b1;
    roots_tb[40] = 12'd12;
    is_tb[41] = 1'b0;
    roots_tb[41] = 12'd13;
    is_tb[50] = 1'b1;
    is_defects[50] = 1'b1;
    roots_tb[50] = 12'd4095;
    push_expected();
    run_scan(-1);
    check_run("bnd");
    e = '0;
    e[12] = 1'b1;
    vectors++;
    if (snap_bnd !== e) begin
      miscompares++;
      $display("FAIL bnd_only_bit12: got %h want %h", snap_bnd, e);
    end
    vectors++;
    if (snap_odd !== '0) begin
      miscompares++;
      $display("FAIL bnd_oor_odd: got %h want 0", snap_odd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pair_cancel();
    test_triple();
    test_last_index();
    test_reset_abort();
    test_out_of_range();
    test_back_to_back();
    test_random();
`ifdef ROOT_BOUNDARY_TRACK_EN
    test_boundary();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
